hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//   Downstream consumer of the combinational Booth multiplier's HI/LO outputs. Owns the architectural HI/LO registers.
//   Latches operands, drives the multiplier and captures its product. Also runs a multi-cycle signed restoring divide and handles MTHI/MTLO writes.
//   Reports busy/done to the CPU control unit.
// PARAMETERS
//   DATA_WIDTH  32  operand / HI / LO width
//   MUL_WAIT    1   cycles allowed for the multiplier's combinational path before capture (>=1)
// PORTS
//   clk       in   1           system clock, rising edge
//   rst_n     in   1           asynchronous active-low reset
//   start     in   1           request strobe; sampled only while busy==0
//   op        in   2           00 MUL, 01 DIV, 10 MTHI, 11 MTLO
//   a         in   DATA_WIDTH  operand A / dividend / MT data
//   b         in   DATA_WIDTH  operand B / divisor
//   mul_q     out  DATA_WIDTH  latched A to multiplier Q
//   mul_m     out  DATA_WIDTH  latched B to multiplier M
//   mul_hi    in   DATA_WIDTH  multiplier HI (combinational from mul_q/mul_m)
//   mul_lo    in   DATA_WIDTH  multiplier LO
//   busy      out  1           operation in progress
//   done      out  1           one-cycle pulse; hi/lo hold new result
//   hi        out  DATA_WIDTH  HI register
//   lo        out  DATA_WIDTH  LO register
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE. hi, lo, mul_q, mul_m = 0. busy = done = 0. Divider regs = 0. Reset mid-op aborts; no partial write.
//   FSM: IDLE -> MUL | DIV -> WB -> IDLE. MTHI/MTLO complete in IDLE, with no state change.
//   Edge E0 = first edge with start=1 and busy=0. start while busy=1 is ignored (not queued).
//   MUL: E0 latches mul_q=a, mul_m=b and busy=1. At E(MUL_WAIT), {hi,lo} <= {mul_hi,mul_lo}, done=1, busy=0.
//   DIV: E0 latches |a|, |b|, sign flags and busy=1. E1..E(DATA_WIDTH) run one restoring step each.
//     E(DATA_WIDTH+1) is WB: write the sign-corrected results, done=1, busy=0.
//     LO = quotient, truncated toward zero; negated if sign(a)^sign(b). HI = remainder, carrying the sign of a.
//     Abs of most-negative value: handled as unsigned magnitude in a DATA_WIDTH+1 bit datapath; no overflow trap.
//     The divide-by-zero result is defined under CONFIGURATION.
//   MTHI/MTLO: at E0, hi<=a (or lo<=a). done=1 in the cycle after E0. busy stays 0.
//   done is high exactly one cycle. A new start is accepted in the done cycle.
//   mul_q/mul_m hold their last values when not in MUL.
// CONFIGURATION
//   HILO_DIVZERO_FLAG_EN defined: adds output div_zero (1 bit), reset 0.
//     On DIV with b==0: skip iterations. WB at E1 with lo={DATA_WIDTH{1'b1}}, hi=a, div_zero=1 for the done cycle.
//   Undefined: no port. b==0 runs the full iterations, giving lo=all-ones and hi=a via normal restoring math (same latency as any DIV).
// STRUCTURE
//   Package hilo_pkg: op encodings (OP_MUL, OP_DIV, OP_MTHI, OP_MTLO), FSM state enum, default DATA_WIDTH.
//   Sub-module hilo_div_core: restoring divider datapath (magnitudes in, quotient/remainder out, step-enable input, iteration counter).
//     The FSM and HI/LO registers stay in this module.
//   The multiplier is instantiated outside, in the execute stage, wired via mul_q/mul_m/mul_hi/mul_lo.
// TESTING
//   Bench instantiates boothmul beside this block.
//   MUL a=10, b=-5 -> done after E1; hi=32'hFFFFFFFF, lo=32'hFFFFFFCE.
//   DIV a=-7, b=2 -> done after E33; lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). busy high E0..E32.
//   DIV a=100, b=0 -> lo=32'hFFFFFFFF, hi=100. With the flag enabled: done after E1 with div_zero=1.
//   MTHI a=32'h1234 then MUL a=2000, b=2000 -> hi=0x1234 after the first done. Then hi=0, lo=4000000.
//   start pulsed at E5 of a DIV (busy=1) -> ignored; one done only; result unchanged.
//   rst_n low at E10 of a DIV -> hi=lo=0, busy=0 immediately. No done. The next MUL works normally.

Source files
------------

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared encodings for the HI/LO multiply/divide controller
// Purpose: op encodings, FSM state type and default data width used by
//          hilo_muldiv_ctrl and hilo_div_core.
// Ports:   none (package).
package hilo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_div_core.sv
// rtl/hilo_div_core.sv - unsigned restoring divider datapath, one quotient bit per step
// Purpose: holds divisor, partial remainder and quotient shift register plus
//          the iteration counter; the sign handling lives in the parent.
// Ports:   clk, rst_n     clock, async active-low reset
//          load           capture dividend/divisor magnitudes, clear counter
//          step           run one restoring iteration
//          dividend       |a| as unsigned magnitude
//          divisor        |b| as unsigned magnitude
//          quotient       quotient register (holds dividend right after load)
//          remainder      partial / final remainder
//          last           all DATA_WIDTH iterations have run
module hilo_div_core
  import hilo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  last
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] dvs;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH:0]   diff;

  // One extra bit on the shifted remainder so magnitudes up to 2^(W-1)
  // (abs of the most-negative operand) never wrap; diff's MSB is the borrow.
  always_comb begin
    rem_sh = {rem, quo[DATA_WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= '0;
    end else if (step) begin
      if (!diff[DATA_WIDTH]) begin
        rem <= diff[DATA_WIDTH-1:0];
        quo <= {quo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_sh[DATA_WIDTH-1:0];
        quo <= {quo[DATA_WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
  assign last      = (cnt == CW'(DATA_WIDTH));

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO register owner: multiply capture, signed divide, MTHI/MTLO
// Purpose: latches operands for the external combinational multiplier and
//          captures its product, sequences a signed restoring divide through
//          hilo_div_core, and services MTHI/MTLO writes.
// Config:  HILO_DIVZERO_FLAG_EN adds output div_zero and a one-step
//          divide-by-zero shortcut.
// Ports:   clk, rst_n        clock, async active-low reset
//          start, op, a, b   request strobe, opcode, operands
//          mul_q, mul_m      latched operands to the multiplier
//          mul_hi, mul_lo    multiplier product
//          busy, done        op in progress / one-cycle completion pulse
//          hi, lo            architectural HI/LO registers
//          div_zero          (optional) divide-by-zero flag with done
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MUL_WAIT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] mul_q,
  output logic [DATA_WIDTH-1:0] mul_m,
  input  logic [DATA_WIDTH-1:0] mul_hi,
  input  logic [DATA_WIDTH-1:0] mul_lo,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
`ifdef HILO_DIVZERO_FLAG_EN
  ,
  output logic                  div_zero
`endif
);

  localparam int MW = $clog2(MUL_WAIT + 1);

  state_e                state, state_nx;
  logic                  accept;
  logic                  load_div, step_div, mul_capture, div_write;
  logic                  mt_done;
  logic                  sign_a, neg_q;
  logic [MW-1:0]         mul_cnt;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH-1:0] quo, rem;
  logic [DATA_WIDTH-1:0] quo_s, rem_s;
  logic                  div_last;
  logic                  dz_skip;

`ifdef HILO_DIVZERO_FLAG_EN
  logic b_zero;
  assign dz_skip = b_zero;
`else
  assign dz_skip = 1'b0;
`endif

  // WB is the done cycle and accepts a new request just like IDLE.
  assign busy   = (state == S_MUL) || (state == S_DIV);
  assign done   = (state == S_WB) || mt_done;
  assign accept = start && !busy;

  // Two's-complement negate is the exact unsigned magnitude, including the
  // most-negative value (which maps to 2^(W-1)).
  assign a_mag = a[DATA_WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[DATA_WIDTH-1] ? (~b + 1'b1) : b;

  // Before any step the quotient register still holds |a|, so the
  // divide-by-zero shortcut restores hi = a from it.
  assign quo_s = neg_q  ? (~quo + 1'b1) : quo;
  assign rem_s = sign_a ? (~rem + 1'b1) : rem;

  hilo_div_core #(.DATA_WIDTH(DATA_WIDTH)) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_div),
    .step      (step_div),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  always_comb begin
    state_nx    = state;
    load_div    = 1'b0;
    step_div    = 1'b0;
    mul_capture = 1'b0;
    div_write   = 1'b0;
    case (state)
      S_IDLE, S_WB: begin
        state_nx = S_IDLE;
        if (accept) begin
          if (op == OP_MUL) begin
            state_nx = S_MUL;
          end else if (op == OP_DIV) begin
            state_nx = S_DIV;
            load_div = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mul_cnt == MW'(MUL_WAIT - 1)) begin
          mul_capture = 1'b1;
          state_nx    = S_WB;
        end
      end
      S_DIV: begin
        if (div_last || dz_skip) begin
          div_write = 1'b1;
          state_nx  = S_WB;
        end else begin
          step_div = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mt_done <= 1'b0;
      mul_q   <= '0;
      mul_m   <= '0;
      mul_cnt <= '0;
      sign_a  <= 1'b0;
      neg_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef HILO_DIVZERO_FLAG_EN
      b_zero   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      mt_done <= accept && ((op == OP_MTHI) || (op == OP_MTLO));

      if (accept && (op == OP_MUL)) begin
        mul_q   <= a;
        mul_m   <= b;
        mul_cnt <= '0;
      end else if ((state == S_MUL) && !mul_capture) begin
        mul_cnt <= mul_cnt + 1'b1;
      end

      if (accept && (op == OP_DIV)) begin
        sign_a <= a[DATA_WIDTH-1];
        neg_q  <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
`ifdef HILO_DIVZERO_FLAG_EN
        b_zero <= (b == '0);
`endif
      end

`ifdef HILO_DIVZERO_FLAG_EN
      div_zero <= div_write && b_zero;
`endif

      if (accept && (op == OP_MTHI)) begin
        hi <= a;
      end else if (accept && (op == OP_MTLO)) begin
        lo <= a;
      end else if (mul_capture) begin
        hi <= mul_hi;
        lo <= mul_lo;
      end else if (div_write) begin
        if (dz_skip) begin
          hi <= sign_a ? (~quo + 1'b1) : quo;
          lo <= '1;
        end else begin
          hi <= rem_s;
          lo <= quo_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - self-checking bench for hilo_muldiv_ctrl with a multiplier stand-in
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic [31:0] mul_q, mul_m, mul_hi, mul_lo, hi, lo;
  logic        busy, done;
`ifdef HILO_DIVZERO_FLAG_EN
  logic        div_zero;
`endif
  logic signed [63:0] prod;

  always #5 clk = ~clk;

  // Behavioural stand-in for the Booth multiplier: signed 32x32 -> 64.
  assign prod   = $signed(mul_q) * $signed(mul_m);
  assign mul_hi = prod[63:32];
  assign mul_lo = prod[31:0];

  hilo_muldiv_ctrl #(.DATA_WIDTH(32), .MUL_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mul_q(mul_q), .mul_m(mul_m), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef HILO_DIVZERO_FLAG_EN
    , .div_zero(div_zero)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic        dz;
  } vec_t;

  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;
  int   div0_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("v%0d_busy_e0", idx), busy, (v.op == OP_MUL || v.op == OP_DIV));
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d_latency", idx), n, v.lat);
    if (done) begin
      chk($sformatf("v%0d_hi", idx), hi, v.hi);
      chk($sformatf("v%0d_lo", idx), lo, v.lo);
      chk($sformatf("v%0d_busy_done", idx), busy, 0);
`ifdef HILO_DIVZERO_FLAG_EN
      chk($sformatf("v%0d_div_zero", idx), div_zero, v.dz);
`endif
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", idx), done, 0);
    end
  endtask

  initial begin
`ifdef HILO_DIVZERO_FLAG_EN
    div0_lat = 1;
`else
    div0_lat = 33;
`endif
    vecs[0] = '{OP_MUL,  32'd10,         -32'sd5,      32'hFFFFFFFF, 32'hFFFFFFCE, 1,  1'b0};
    vecs[1] = '{OP_DIV,  -32'sd7,        32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
    vecs[2] = '{OP_DIV,  32'd100,        32'd0,        32'd100,      32'hFFFFFFFF, div0_lat, 1'b1};
    vecs[3] = '{OP_MTHI, 32'h1234,       32'd0,        32'h1234,     32'hFFFFFFFF, 0,  1'b0};
    vecs[4] = '{OP_MUL,  32'd2000,       32'd2000,     32'h0,        32'd4000000,  1,  1'b0};
    vecs[5] = '{OP_DIV,  32'd7,          -32'sd2,      32'h1,        32'hFFFFFFFD, 33, 1'b0};
    vecs[6] = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h0,        32'h80000000, 33, 1'b0};
    vecs[7] = '{OP_DIV,  32'h80000000,   32'd7,        32'hFFFFFFFE, 32'hEDB6DB6E, 33, 1'b0};
    vecs[8] = '{OP_MTLO, 32'h5A5A,       32'd0,        32'hFFFFFFFE, 32'h5A5A,     0,  1'b0};
    vecs[9] = '{OP_MUL,  -32'sd3,        -32'sd4,      32'h0,        32'hC,        1,  1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mul_q", mul_q, 0);
    chk("reset_mul_m", mul_m, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(i, vecs[i]);

    // start while a DIV is busy must be dropped, not queued.
    begin
      int ndone, first;
      ndone = 0; first = 0;
      @(negedge clk);
      op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 1; e <= 40; e++) begin
        if (e == 5) begin
          @(negedge clk);
          op = OP_MUL; a = 32'd1; b = 32'd1; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (done) begin
          ndone++;
          if (first == 0) first = e;
        end
      end
      chk("ign_done_count", ndone, 1);
      chk("ign_done_edge", first, 33);
      chk("ign_hi", hi, 32'd2);
      chk("ign_lo", lo, 32'd14);
      chk("ign_mul_q", mul_q, 32'hFFFFFFFD);
    end

    // Reset in the middle of a DIV aborts with no writeback.
    begin
      int ndone;
      ndone = 0;
      @(negedge clk);
      op = OP_DIV; a = -32'sd7; b = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 40; e++) begin
        @(posedge clk); #1;
        if (done) ndone++;
      end
      chk("rst_no_done", ndone, 0);
      chk("rst_hi_after", hi, 0);
      run_op(10, vecs[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
